bht_ctrl: RTL

- Owns a single-port branch history table of 2-bit saturating counters and schedules access to it.
- Two requesters share the table: the fetch-side prediction lookup, and the resolve-side counter update.
- Clears the table after reset, buffers updates in a 2-entry FIFO, arbitrates lookups against read-modify-write updates.
- Sits between the fetch stage and branch resolution in the pipeline.

---
 rtl/bht_pkg.sv | 39 +++
 rtl/bht_upd_fifo.sv | 45 ++++
 rtl/bht_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bht_pkg.sv
// Shared types and counter update rule for the branch history table controller.
// Define BHT_HYST_EN to replace the saturating counter with the hysteresis FSM.
package bht_pkg;

    // Widest table index the FIFO entry can carry; raise this for IDX_W > 10.
    localparam int unsigned BHT_IDX_W = 10;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        UPD_RD = 2'd2,
        UPD_WR = 2'd3
    } state_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic [BHT_IDX_W-1:0] idx;
        logic                 taken;
    } upd_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
`ifdef BHT_HYST_EN
        case (c)
            CTR_SNT: ctr_next = t ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_next = t ? CTR_ST  : CTR_SNT;
            CTR_WT:  ctr_next = t ? CTR_ST  : CTR_SNT;
            default: ctr_next = t ? CTR_ST  : CTR_WT;
        endcase
`else
        if (t) ctr_next = (c == CTR_ST)  ? CTR_ST  : c + 2'd1;
        else   ctr_next = (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
`endif
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Two-entry FIFO holding pending counter updates in arrival order.
module bht_upd_fifo
    import bht_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  upd_entry_t push_data,
    input  logic       pop,
    output upd_entry_t head,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    upd_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: clears the table, serves 1-cycle lookups and
// applies buffered read-modify-write counter updates. Optional: BHT_HYST_EN.
module bht_ctrl
    import bht_pkg::*;
#(
    parameter int unsigned IDX_W = BHT_IDX_W,
    parameter int unsigned PC_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_valid,
    output logic            pred_ready,
    input  logic [PC_W-1:0] pred_pc,
    output logic            resp_valid,
    output logic            resp_taken,
    output logic [1:0]      resp_ctr,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            init_done,
    output logic            busy
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0]       table_q [DEPTH];
    state_e           state;
    logic [IDX_W-1:0] init_idx;
    logic [1:0]       ctr_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       fifo_count;
    upd_entry_t       fifo_head;
    upd_entry_t       push_data;

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] head_idx;
    logic             pred_fire;
    logic             upd_fire;
    logic             pc_unused;

    logic             tbl_we;
    logic [IDX_W-1:0] tbl_widx;
    logic [1:0]       tbl_wdata;

    assign pred_idx   = pred_pc[IDX_W+1:2];
    assign head_idx   = IDX_W'(fifo_head.idx);
    assign pc_unused  = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                          upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    assign upd_ready  = init_done && !fifo_full;
    assign pred_ready = (state == IDLE) && init_done && !fifo_full;
    assign pred_fire  = pred_valid && pred_ready;
    assign upd_fire   = upd_valid && upd_ready;
    assign resp_taken = resp_ctr[1];

    assign push_data.idx   = BHT_IDX_W'(upd_pc[IDX_W+1:2]);
    assign push_data.taken = upd_taken;

    bht_upd_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (upd_fire),
        .push_data (push_data),
        .pop       (state == UPD_WR),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Single write port: clear sweep during INIT, counter write-back in UPD_WR.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_widx  = init_idx;
        tbl_wdata = CTR_SNT;
        if (state == INIT) begin
            tbl_we = 1'b1;
        end else if (state == UPD_WR) begin
            tbl_we    = 1'b1;
            tbl_widx  = head_idx;
            tbl_wdata = ctr_next(ctr_q, fifo_head.taken);
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) table_q[tbl_widx] <= tbl_wdata;
    end

    // busy is registered from the post-edge state and FIFO occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            init_idx   <= '0;
            init_done  <= 1'b0;
            ctr_q      <= CTR_SNT;
            resp_valid <= 1'b0;
            resp_ctr   <= CTR_SNT;
            busy       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                INIT: begin
                    init_idx <= init_idx + IDX_W'(1);
                    busy     <= 1'b1;
                    if (init_idx == IDX_W'(DEPTH - 1)) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                IDLE: begin
                    if (fifo_full || (!pred_fire && !fifo_empty)) begin
                        state <= UPD_RD;
                        busy  <= 1'b1;
                    end else begin
                        busy <= !fifo_empty || upd_fire;
                        if (pred_fire) begin
                            resp_valid <= 1'b1;
                            resp_ctr   <= table_q[pred_idx];
                        end
                    end
                end
                UPD_RD: begin
                    ctr_q <= table_q[head_idx];
                    state <= UPD_WR;
                    busy  <= 1'b1;
                end
                UPD_WR: begin
                    state <= IDLE;
                    busy  <= (fifo_count == 2'd2) || upd_fire;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
